// File: rtl/cache_nway_if.sv
// Bus bundle between the CPU memory port, the cache and physical memory.
// The cache takes the slave view; the CPU/memory side takes the master view.
interface cache_nway_if #(
   parameter int LINE = 128
);
   logic [15:0]     mem_address;
   logic            mem_read;
   logic            mem_write;
   logic [1:0]      mem_byte_enable;
   logic [15:0]     mem_wdata;
   logic [15:0]     mem_rdata;
   logic            mem_resp;
   logic [15:0]     pmem_address;
   logic            pmem_read;
   logic            pmem_write;
   logic [LINE-1:0] pmem_wdata;
   logic [LINE-1:0] pmem_rdata;
   logic            pmem_resp;
   logic [15:0]     hit_count;
   logic [15:0]     miss_count;

   modport slave (
      input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
             pmem_rdata, pmem_resp,
      output mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write,
             pmem_wdata, hit_count, miss_count
   );

   modport master (
      output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
             pmem_rdata, pmem_resp,
      input  mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write,
             pmem_wdata, hit_count, miss_count
   );
endinterface

// File: rtl/cache_nway.sv
// N-way set-associative write-back/write-allocate L1 cache with tree PLRU
// replacement, invalid-way-first fill and saturating hit/miss counters.
module cache_nway #(
   parameter int WAYS       = 4,
   parameter int SETS       = 8,
   parameter int LINE_BYTES = 16
) (
   input logic         clk,
   input logic         reset,
   cache_nway_if.slave bus
);
   localparam int OFF  = $clog2(LINE_BYTES);
   localparam int IDX  = $clog2(SETS);
   localparam int TAG  = 16 - IDX - OFF;
   localparam int LINE = 8 * LINE_BYTES;
   localparam int WIDX = $clog2(WAYS);

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

   state_t          state;
   logic [TAG-1:0]  tags  [SETS][WAYS];
   logic [LINE-1:0] data  [SETS][WAYS];
   logic [WAYS-1:0] valid [SETS];
   logic [WAYS-1:0] dirty [SETS];
   logic [WAYS-2:0] plru  [SETS];

   logic [TAG-1:0]  tag;
   logic [IDX-1:0]  idx;
   logic [OFF-2:0]  word;
   logic            unused_bit;
   logic            req;
   logic            hit;
   logic            has_invalid;
   logic [WIDX-1:0] hit_way;
   logic [WIDX-1:0] inv_way;
   logic [WIDX-1:0] victim_sel;
   logic [LINE-1:0] hit_line;
   logic [LINE-1:0] merged;
   logic            hit_we;
   logic            fill_we;

   logic [WIDX-1:0] victim_q;
   logic [TAG-1:0]  miss_tag_q;
   logic [IDX-1:0]  miss_idx_q;
   logic            pmem_read_q;
   logic            pmem_write_q;
   logic            filled_q;
   logic [15:0]     pmem_addr_q;
   logic [15:0]     hit_count_q;
   logic [15:0]     miss_count_q;

   // Walk from the root following the tree bits; the leaf reached is the victim.
   function automatic logic [WIDX-1:0] plru_victim(input logic [WAYS-2:0] bits);
      int node;
      node = 0;
      for (int l = 0; l < WIDX; l++) node = 2 * node + 1 + int'(bits[node]);
      return WIDX'(node - (WAYS - 1));
   endfunction

   function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WIDX-1:0] way);
      logic [WAYS-2:0] next;
      logic            d;
      int              node;
      next = bits;
      node = 0;
      for (int l = 0; l < WIDX; l++) begin
         d          = way[WIDX-1-l];
         next[node] = ~d;
         node       = 2 * node + 1 + int'(d);
      end
      return next;
   endfunction

   assign tag        = bus.mem_address[15 -: TAG];
   assign idx        = bus.mem_address[OFF +: IDX];
   assign word       = bus.mem_address[1 +: OFF-1];
   assign unused_bit = bus.mem_address[0];

   always_comb begin
      req         = bus.mem_read | bus.mem_write;
      hit         = 1'b0;
      hit_way     = '0;
      has_invalid = 1'b0;
      inv_way     = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid[idx][w] && tags[idx][w] == tag) begin
            hit     = 1'b1;
            hit_way = WIDX'(w);
         end
         if (!valid[idx][w]) begin
            has_invalid = 1'b1;
            inv_way     = WIDX'(w);
         end
      end
      victim_sel = has_invalid ? inv_way : plru_victim(plru[idx]);
      hit_line   = data[idx][hit_way];
      merged     = hit_line;
      if (bus.mem_byte_enable[0]) merged[{word, 4'b0000} +: 8] = bus.mem_wdata[7:0];
      if (bus.mem_byte_enable[1]) merged[{word, 4'b1000} +: 8] = bus.mem_wdata[15:8];
   end

   assign bus.mem_resp     = (state == IDLE) && req && hit;
   assign bus.mem_rdata    = hit_line[{word, 4'b0000} +: 16];
   assign bus.pmem_wdata   = data[miss_idx_q][victim_q];
   assign bus.pmem_read    = pmem_read_q;
   assign bus.pmem_write   = pmem_write_q;
   assign bus.pmem_address = pmem_addr_q;
   assign bus.hit_count    = hit_count_q;
   assign bus.miss_count   = miss_count_q;

   assign hit_we  = !reset && bus.mem_resp && bus.mem_write;
   assign fill_we = !reset && (state == ALLOCATE) && bus.pmem_resp;

   always_ff @(posedge clk) begin
      if (fill_we) begin
         data[miss_idx_q][victim_q] <= bus.pmem_rdata;
         tags[miss_idx_q][victim_q] <= miss_tag_q;
      end else if (hit_we) begin
         data[idx][hit_way] <= merged;
      end
   end

   // filled_q marks the hit that completes a miss so it is not counted as a hit.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
         pmem_addr_q  <= '0;
         victim_q     <= '0;
         miss_tag_q   <= '0;
         miss_idx_q   <= '0;
         filled_q     <= 1'b0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid[s] <= '0;
            dirty[s] <= '0;
            plru[s]  <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               filled_q <= 1'b0;
               if (req && hit) begin
                  plru[idx] <= plru_touch(plru[idx], hit_way);
                  if (bus.mem_write && bus.mem_byte_enable != 2'b00)
                     dirty[idx][hit_way] <= 1'b1;
                  if (!filled_q && hit_count_q != 16'hFFFF)
                     hit_count_q <= hit_count_q + 16'd1;
               end else if (req) begin
                  if (miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
                  victim_q   <= victim_sel;
                  miss_tag_q <= tag;
                  miss_idx_q <= idx;
                  if (valid[idx][victim_sel] && dirty[idx][victim_sel]) begin
                     state        <= WRITEBACK;
                     pmem_write_q <= 1'b1;
                     pmem_addr_q  <= {tags[idx][victim_sel], idx, {OFF{1'b0}}};
                  end else begin
                     state       <= ALLOCATE;
                     pmem_read_q <= 1'b1;
                     pmem_addr_q <= {tag, idx, {OFF{1'b0}}};
                  end
               end
            end
            WRITEBACK: begin
               if (bus.pmem_resp) begin
                  state        <= ALLOCATE;
                  pmem_write_q <= 1'b0;
                  pmem_read_q  <= 1'b1;
                  pmem_addr_q  <= {miss_tag_q, miss_idx_q, {OFF{1'b0}}};
               end
            end
            ALLOCATE: begin
               if (bus.pmem_resp) begin
                  state                       <= IDLE;
                  pmem_read_q                 <= 1'b0;
                  valid[miss_idx_q][victim_q] <= 1'b1;
                  dirty[miss_idx_q][victim_q] <= 1'b0;
                  filled_q                    <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
